// File: rtl/montacargas_cabina_pkg.sv
// Shared types for the freight-elevator shaft model: motor codes, cabin states, floor indices.
// Latency: none (types and constants only).
// Backpressure: none. MONTACARGAS_CABINA_INERCIA_EN adds the ST_START state.
package montacargas_pkg;

    typedef enum logic [1:0] {
        MOTOR_STOP = 2'b00,
        MOTOR_UP   = 2'b01,
        MOTOR_DOWN = 2'b10,
        MOTOR_INV  = 2'b11
    } motor_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MOV_UP   = 3'd1,
        ST_MOV_DOWN = 3'd2,
        ST_FAULT    = 3'd3
`ifdef MONTACARGAS_CABINA_INERCIA_EN
        , ST_START  = 3'd4
`endif
    } cabin_state_t;

    // Floor indices as seen by the controller (floor 1 is the bottom).
    localparam logic [1:0] FLOOR_1 = 2'd0;
    localparam logic [1:0] FLOOR_2 = 2'd1;
    localparam logic [1:0] FLOOR_3 = 2'd2;

    // Position of a floor, in steps, counted from the bottom of the shaft.
    function automatic int floor_pos(input int floor_idx, input int travel_ticks);
        return floor_idx * travel_ticks;
    endfunction

endpackage

// File: rtl/montacargas_fc_decode.sv
// Window compare of cabin position against the three floor limit-switch zones.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow i_pos continuously.
module montacargas_fc_decode #(
    parameter int TRAVEL_TICKS = 8,
    parameter int ZONE         = 1,
    parameter int PW           = 5
) (
    input  logic [PW-1:0] i_pos,
    output logic          o_fc1,
    output logic          o_fc2,
    output logic          o_fc3
);

    // Zones never overlap because ZONE < TRAVEL_TICKS/2, so at most one switch is high.
    localparam logic [PW-1:0] W1_HI = PW'(ZONE);
    localparam logic [PW-1:0] W2_LO = PW'(TRAVEL_TICKS - ZONE);
    localparam logic [PW-1:0] W2_HI = PW'(TRAVEL_TICKS + ZONE);
    localparam logic [PW-1:0] W3_LO = PW'(2 * TRAVEL_TICKS - ZONE);

    assign o_fc1 = (i_pos <= W1_HI);
    assign o_fc2 = (i_pos >= W2_LO) && (i_pos <= W2_HI);
    assign o_fc3 = (i_pos >= W3_LO);

endmodule

// File: rtl/montacargas_cabina.sv
// Freight-elevator cabin plant: integrates motor commands into position and drives Fc1..Fc3.
// Latency: command at edge n sets state at edge n, first pos step at edge n+1 (STEP_DIV=1).
// Backpressure: none; overrun or code 11 latches a sticky fault. MONTACARGAS_CABINA_INERCIA_EN adds a start delay.
module montacargas_cabina
    import montacargas_pkg::*;
#(
    parameter int TRAVEL_TICKS = 8,
    parameter int ZONE         = 1,
    parameter int STEP_DIV     = 1,
    parameter int RESET_FLOOR  = 0,
    parameter int START_DELAY  = 3,
    localparam int PW          = $clog2(2 * TRAVEL_TICKS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    motor,
    output logic          Fc1,
    output logic          Fc2,
    output logic          Fc3,
    output logic [PW-1:0] pos,
    output logic          moving,
    output logic          fault
);

    localparam int            PRW     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] POS_TOP = PW'(2 * TRAVEL_TICKS);
    localparam logic [PW-1:0] POS_RST = PW'(floor_pos(RESET_FLOOR, TRAVEL_TICKS));

    // Reject geometries where zones would overlap or the reset floor does not exist.
    if (TRAVEL_TICKS < 4 || (TRAVEL_TICKS % 2) != 0 || ZONE >= TRAVEL_TICKS / 2 ||
        STEP_DIV < 1 || START_DELAY < 1 || RESET_FLOOR < 0 || RESET_FLOOR > int'(FLOOR_3)) begin : g_param_check
        $error("montacargas_cabina: illegal parameter set");
    end

    cabin_state_t   r_state, w_state_nxt;
    logic [PW-1:0]  r_pos, w_pos_nxt;
    logic [PRW-1:0] r_presc, w_presc_nxt;
    motor_t         w_cmd;
    motor_t         w_dir_cmd;
    logic           w_step_en;
    logic           w_up;
`ifdef MONTACARGAS_CABINA_INERCIA_EN
    localparam int CW = $clog2(START_DELAY + 1);
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic           r_dir, w_dir_nxt;   // 1 = pending ascent, 0 = pending descent
`endif

    assign w_cmd     = motor_t'(motor);
    assign w_step_en = ((r_state == ST_MOV_UP) || (r_state == ST_MOV_DOWN)) &&
                       (r_presc == PRW'(STEP_DIV - 1));

    // Next-state, position and prescaler update; a direction change always passes through IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_presc_nxt = r_presc;
        w_up        = (r_state == ST_MOV_UP);
        w_dir_cmd   = w_up ? MOTOR_UP : MOTOR_DOWN;
`ifdef MONTACARGAS_CABINA_INERCIA_EN
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
`endif
        case (r_state)
            ST_IDLE: begin
                w_presc_nxt = '0;
                case (w_cmd)
                    MOTOR_STOP: w_state_nxt = ST_IDLE;
                    MOTOR_UP: begin
`ifdef MONTACARGAS_CABINA_INERCIA_EN
                        w_state_nxt = (r_pos == POS_TOP) ? ST_FAULT : ST_START;
                        w_dir_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
`else
                        w_state_nxt = (r_pos == POS_TOP) ? ST_FAULT : ST_MOV_UP;
`endif
                    end
                    MOTOR_DOWN: begin
`ifdef MONTACARGAS_CABINA_INERCIA_EN
                        w_state_nxt = (r_pos == '0) ? ST_FAULT : ST_START;
                        w_dir_nxt   = 1'b0;
                        w_cnt_nxt   = '0;
`else
                        w_state_nxt = (r_pos == '0) ? ST_FAULT : ST_MOV_DOWN;
`endif
                    end
                    default: w_state_nxt = ST_FAULT;
                endcase
            end
`ifdef MONTACARGAS_CABINA_INERCIA_EN
            ST_START: begin
                w_dir_cmd = r_dir ? MOTOR_UP : MOTOR_DOWN;
                if (w_cmd == MOTOR_INV) begin
                    w_state_nxt = ST_FAULT;
                end else if (w_cmd != w_dir_cmd) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CW'(START_DELAY - 1)) begin
                    w_state_nxt = r_dir ? ST_MOV_UP : ST_MOV_DOWN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
`endif
            ST_MOV_UP, ST_MOV_DOWN: begin
                w_presc_nxt = w_step_en ? '0 : r_presc + PRW'(1);
                if (w_cmd == MOTOR_INV) begin
                    w_state_nxt = ST_FAULT;
                    w_presc_nxt = '0;
                end else if (w_cmd != w_dir_cmd) begin
                    // Stop or opposite command: park for at least one cycle.
                    w_state_nxt = ST_IDLE;
                    w_presc_nxt = '0;
                end else if (w_step_en) begin
                    if (w_up && (r_pos == POS_TOP)) begin
                        w_state_nxt = ST_FAULT;
                    end else if (!w_up && (r_pos == '0)) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_pos_nxt = w_up ? (r_pos + PW'(1)) : (r_pos - PW'(1));
                    end
                end
            end
            ST_FAULT: w_state_nxt = ST_FAULT;
            default:  w_state_nxt = ST_FAULT;
        endcase
    end

    // State, position and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_pos   <= POS_RST;
            r_presc <= '0;
`ifdef MONTACARGAS_CABINA_INERCIA_EN
            r_cnt   <= '0;
            r_dir   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            r_presc <= w_presc_nxt;
`ifdef MONTACARGAS_CABINA_INERCIA_EN
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
`endif
        end
    end

    assign pos    = r_pos;
    assign fault  = (r_state == ST_FAULT);
`ifdef MONTACARGAS_CABINA_INERCIA_EN
    assign moving = (r_state == ST_MOV_UP) || (r_state == ST_MOV_DOWN) || (r_state == ST_START);
`else
    assign moving = (r_state == ST_MOV_UP) || (r_state == ST_MOV_DOWN);
`endif

    montacargas_fc_decode #(
        .TRAVEL_TICKS (TRAVEL_TICKS),
        .ZONE         (ZONE),
        .PW           (PW)
    ) u_fc_decode (
        .i_pos (r_pos),
        .o_fc1 (Fc1),
        .o_fc2 (Fc2),
        .o_fc3 (Fc3)
    );

endmodule

// File: tb/tb_montacargas_cabina.sv
// Bench for montacargas_cabina: shaft-level model checked every cycle plus literal checkpoints.
// Latency: inputs change 1 time unit after a rising edge, outputs sampled on the falling edge.
// Backpressure: none. Define MONTACARGAS_CABINA_INERCIA_EN to exercise the start-delay build.
module tb_montacargas_cabina;

    localparam int T   = 8;
    localparam int Z   = 1;
    localparam int TOP = 2 * T;
    localparam int SD  = 3;
    localparam int PW  = $clog2(2 * T + 1);

    logic          clk;
    logic          rst;
    logic [1:0]    motor;
    logic          Fc1, Fc2, Fc3;
    logic [PW-1:0] pos;
    logic          moving;
    logic          fault;

    int n_checks = 0;
    int n_fail   = 0;

    montacargas_cabina dut (
        .clk    (clk),
        .rst    (rst),
        .motor  (motor),
        .Fc1    (Fc1),
        .Fc2    (Fc2),
        .Fc3    (Fc3),
        .pos    (pos),
        .moving (moving),
        .fault  (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Shaft model: position in steps, current direction (+1/-1/0), sticky fault, pending start.
    int m_pos   = 0;
    int m_dir   = 0;
    bit m_fault = 1'b0;
    bit m_valid = 1'b0;
    int m_start = 0;
    int m_pend  = 0;

    function automatic bit near_floor(input int p, input int k);
        int d;
        d = p - k * T;
        if (d < 0) d = -d;
        return (d <= Z);
    endfunction

    always @(posedge clk) begin
        int cmd;
        int d;
        cmd = int'(motor);
        m_valid = 1'b1;
        if (!rst) begin
            m_pos = 0; m_dir = 0; m_fault = 1'b0; m_start = 0;
        end else if (m_fault) begin
            m_dir = 0;
        end else if (m_start > 0) begin
            if (cmd == 3) begin
                m_fault = 1'b1; m_start = 0;
            end else if (cmd != m_pend) begin
                m_start = 0;
            end else begin
                m_start--;
                if (m_start == 0) m_dir = (m_pend == 1) ? 1 : -1;
            end
        end else if (m_dir == 0) begin
            if (cmd == 3) begin
                m_fault = 1'b1;
            end else if (cmd != 0) begin
                d = (cmd == 1) ? 1 : -1;
                if (m_pos + d < 0 || m_pos + d > TOP) begin
                    m_fault = 1'b1;
                end else begin
`ifdef MONTACARGAS_CABINA_INERCIA_EN
                    m_start = SD; m_pend = cmd;
`else
                    m_dir = d;
`endif
                end
            end
        end else begin
            if (cmd == 3) begin
                m_fault = 1'b1; m_dir = 0;
            end else if (cmd == ((m_dir > 0) ? 1 : 2)) begin
                if (m_pos + m_dir < 0 || m_pos + m_dir > TOP) begin
                    m_fault = 1'b1; m_dir = 0;
                end else begin
                    m_pos = m_pos + m_dir;
                end
            end else begin
                m_dir = 0;
            end
        end
    end

    // Every-cycle comparison of the DUT against the shaft model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pos",    int'(pos),    m_pos);
            chk("model_fault",  int'(fault),  int'(m_fault));
            chk("model_moving", int'(moving), int'((m_dir != 0 || m_start > 0) && !m_fault));
            chk("model_fc1",    int'(Fc1),    int'(near_floor(m_pos, 0)));
            chk("model_fc2",    int'(Fc2),    int'(near_floor(m_pos, 1)));
            chk("model_fc3",    int'(Fc3),    int'(near_floor(m_pos, 2)));
        end
    end

    task automatic step(input logic r, input logic [1:0] m);
        rst   = r;
        motor = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b0;
        motor = 2'b00;
        step(1'b0, 2'b00);
        step(1'b0, 2'b00);
        chk("reset_pos",    int'(pos),    0);
        chk("reset_fc1",    int'(Fc1),    1);
        chk("reset_fc2",    int'(Fc2),    0);
        chk("reset_fc3",    int'(Fc3),    0);
        chk("reset_moving", int'(moving), 0);
        chk("reset_fault",  int'(fault),  0);

`ifdef MONTACARGAS_CABINA_INERCIA_EN
        // Command at edge n: START for three cycles, first increment at edge n+4.
        step(1'b1, 2'b01);
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 2'b01);
            chk("inertia_hold_pos", int'(pos),    0);
            chk("inertia_moving",   int'(moving), 1);
        end
        step(1'b1, 2'b01);
        chk("inertia_first_step", int'(pos), 1);
        step(1'b1, 2'b00);
        chk("inertia_stop", int'(moving), 0);
        step(1'b1, 2'b01);
        step(1'b1, 2'b11);
        chk("inertia_inv_fault", int'(fault), 1);
        step(1'b0, 2'b00);
        chk("inertia_reset_pos", int'(pos), 0);
`else
        // Full ascent: first edge only changes state, then one step per edge.
        for (int i = 1; i <= 17; i++) begin
            step(1'b1, 2'b01);
            chk("asc_pos", int'(pos), i - 1);
            case (i - 1)
                1:  chk("asc_fc1_in",   int'(Fc1), 1);
                2:  chk("asc_fc1_out",  int'(Fc1), 0);
                6:  chk("asc_fc2_pre",  int'(Fc2), 0);
                7:  chk("asc_fc2_in",   int'(Fc2), 1);
                9:  chk("asc_fc2_last", int'(Fc2), 1);
                10: chk("asc_fc2_out",  int'(Fc2), 0);
                14: chk("asc_fc3_pre",  int'(Fc3), 0);
                15: chk("asc_fc3_in",   int'(Fc3), 1);
                default: ;
            endcase
        end
        step(1'b1, 2'b01);
        chk("overrun_fault",  int'(fault),  1);
        chk("overrun_pos",    int'(pos),    16);
        chk("overrun_moving", int'(moving), 0);
        repeat (3) step(1'b1, 2'b00);
        chk("fault_sticky", int'(fault), 1);
        chk("fault_pos",    int'(pos),   16);
        step(1'b0, 2'b00);
        chk("fault_clear",  int'(fault), 0);
        chk("fault_rpos",   int'(pos),   0);

        // Reset in the middle of an ascent.
        repeat (6) step(1'b1, 2'b01);
        chk("mid_pos5",   int'(pos),    5);
        chk("mid_moving", int'(moving), 1);
        step(1'b0, 2'b01);
        chk("mid_rst_pos",    int'(pos),    0);
        chk("mid_rst_fc1",    int'(Fc1),    1);
        chk("mid_rst_moving", int'(moving), 0);
        step(1'b1, 2'b00);

        // Stop at floor 2, then descend to floor 1.
        repeat (9) step(1'b1, 2'b01);
        chk("stop_pos8", int'(pos), 8);
        chk("stop_fc2",  int'(Fc2), 1);
        step(1'b1, 2'b00);
        chk("stop_moving", int'(moving), 0);
        chk("stop_hold",   int'(pos),    8);
        step(1'b1, 2'b00);
        chk("stop_hold2",  int'(pos),    8);
        step(1'b1, 2'b10);
        chk("down_moving", int'(moving), 1);
        chk("down_pos8",   int'(pos),    8);
        for (int j = 1; j <= 8; j++) begin
            step(1'b1, 2'b10);
            chk("down_pos", int'(pos), 8 - j);
            if (8 - j == 2) chk("down_fc1_out", int'(Fc1), 0);
            if (8 - j == 1) chk("down_fc1_in",  int'(Fc1), 1);
        end
        step(1'b1, 2'b00);

        // Direct up-to-down switch parks for exactly one cycle.
        repeat (3) step(1'b1, 2'b01);
        chk("rev_pos2", int'(pos), 2);
        step(1'b1, 2'b10);
        chk("rev_idle_moving", int'(moving), 0);
        chk("rev_idle_pos",    int'(pos),    2);
        step(1'b1, 2'b10);
        chk("rev_down_moving", int'(moving), 1);
        chk("rev_down_pos",    int'(pos),    2);
        step(1'b1, 2'b10);
        chk("rev_step_pos",    int'(pos),    1);
        step(1'b1, 2'b00);
        step(1'b0, 2'b00);

        // Invalid code from IDLE, and descending from the bottom floor.
        step(1'b1, 2'b11);
        chk("inv_fault",  int'(fault),  1);
        chk("inv_moving", int'(moving), 0);
        step(1'b0, 2'b00);
        step(1'b1, 2'b10);
        chk("bottom_down_fault", int'(fault), 1);
        chk("bottom_down_pos",   int'(pos),   0);
        step(1'b0, 2'b00);
`endif
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
